// File: rtl/psel_gen_pkg.sv
// -----------------------------------------------------------------------------
// psel_gen_pkg
//   Shared definitions for the fetch slice that uses psel_gen.
//   N is the fetch width. NUM_SCALAR_BITS is sized to hold any index 0..N
//   inclusive, so "no hit" can be encoded as N itself.
//   Address and instruction typedefs are shared with the fetch consumers.
//   psel_gen itself relies only on its own parameters.
// -----------------------------------------------------------------------------
package psel_gen_pkg;

    localparam int N               = 4;
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

endpackage

// File: rtl/psel_gen_encoder.sv
// -----------------------------------------------------------------------------
// psel_gen_encoder
//   Converts a one-hot vector to a binary index. An all-zero input encodes
//   as WIDTH, meaning "nothing selected". A multi-hot input is not expected;
//   psel_gen drives this block only with its lowest-bit grant.
// Ports:
//   onehot  in  WIDTH     one-hot (or all-zero) selection
//   idx     out OUT_BITS  binary position of the set bit, WIDTH when none set
// -----------------------------------------------------------------------------
module psel_gen_encoder
    import psel_gen_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int OUT_BITS = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]    onehot,
    output logic [OUT_BITS-1:0] idx
);

    always_comb begin
        idx = '0;
        // For a one-hot input, ORing the indices of all set bits gives the
        // single set bit's index. No priority chain is needed.
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | OUT_BITS'(i);
            end
        end
        if (onehot == '0) begin
            idx = OUT_BITS'(WIDTH);
        end
    end

endmodule

// File: rtl/psel_gen.sv
// -----------------------------------------------------------------------------
// psel_gen
//   Multi-grant priority selector. From req it picks up to REQS set bits,
//   starting from the lowest index. Each pick is reported as a one-hot row.
//   The block also reports the union of all rows, an empty flag, and the
//   binary index of the first pick. A registered copy of that index and of
//   the empty flag is provided for consumers in the next cycle.
//   This block has no handshake: the outputs follow req combinationally on
//   every cycle. The registered pair captures them on every clock edge.
// Ports:
//   clock      in  1           system clock
//   reset      in  1           synchronous active-high reset
//   req        in  WIDTH       request bits, bit 0 has highest priority
//   gnt_bus    out REQS*WIDTH  row k = k-th lowest set req bit, one-hot or 0
//   gnt        out WIDTH       OR of all gnt_bus rows
//   empty      out 1           req == 0
//   gnt_idx    out IDX_BITS    binary index of row 0, WIDTH when empty
//   gnt_idx_q  out IDX_BITS    gnt_idx registered (reset 0)
//   empty_q    out 1           empty registered (reset 1)
// -----------------------------------------------------------------------------
module psel_gen
    import psel_gen_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int REQS     = 1,
    parameter int IDX_BITS = $clog2(WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      req,
    output logic [REQS*WIDTH-1:0] gnt_bus,
    output logic [WIDTH-1:0]      gnt,
    output logic                  empty,
    output logic [IDX_BITS-1:0]   gnt_idx,
    output logic [IDX_BITS-1:0]   gnt_idx_q,
    output logic                  empty_q
);

    // Grant chain. Each stage sees the requests that earlier rows have not
    // taken yet, and isolates the lowest of them with x & -x.
    for (genvar k = 0; k < REQS; k++) begin : g_row
        logic [WIDTH-1:0] avail;
        logic [WIDTH-1:0] row;

        if (k == 0) begin : g_first
            assign avail = req;
        end else begin : g_next
            assign avail = g_row[k-1].avail & ~g_row[k-1].row;
        end

        assign row = avail & (~avail + WIDTH'(1));
        assign gnt_bus[k*WIDTH +: WIDTH] = row;
    end

    always_comb begin
        gnt = '0;
        for (int k = 0; k < REQS; k++) begin
            gnt = gnt | gnt_bus[k*WIDTH +: WIDTH];
        end
    end

    assign empty = (req == '0);

    // Row 0 is always the first block of gnt_bus. It is one-hot or zero,
    // so it is always valid input for the encoder.
    psel_gen_encoder #(
        .WIDTH    (WIDTH),
        .OUT_BITS (IDX_BITS)
    ) u_encoder (
        .onehot (gnt_bus[WIDTH-1:0]),
        .idx    (gnt_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_idx_q <= '0;
            empty_q   <= 1'b1;
        end else begin
            gnt_idx_q <= gnt_idx;
            empty_q   <= empty;
        end
    end

endmodule

// File: tb/tb_psel_gen.sv
// -----------------------------------------------------------------------------
// tb_psel_gen
//   Self-checking bench for psel_gen. It instantiates five configurations
//   and drives them from shared request vectors:
//     d1: WIDTH=4, REQS=1
//     d2: WIDTH=4, REQS=2
//     d4: WIDTH=4, REQS=4
//     d8: WIDTH=8, REQS=3 (random requests)
//     w1: WIDTH=1, REQS=1
// -----------------------------------------------------------------------------
module tb_psel_gen;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic [3:0]  req4;
    logic [7:0]  req8;
    logic [0:0]  req1;

    logic [3:0]  d1_bus, d1_gnt;  logic d1_empty, d1_empty_q;  logic [2:0] d1_idx, d1_idx_q;
    logic [7:0]  d2_bus;  logic [3:0] d2_gnt;  logic d2_empty, d2_empty_q;  logic [2:0] d2_idx, d2_idx_q;
    logic [15:0] d4_bus;  logic [3:0] d4_gnt;  logic d4_empty, d4_empty_q;  logic [2:0] d4_idx, d4_idx_q;
    logic [23:0] d8_bus;  logic [7:0] d8_gnt;  logic d8_empty, d8_empty_q;  logic [3:0] d8_idx, d8_idx_q;
    logic [0:0]  w1_bus, w1_gnt;  logic w1_empty, w1_empty_q;  logic [0:0] w1_idx, w1_idx_q;

    psel_gen #(.WIDTH(4), .REQS(1)) d1 (.clock(clock), .reset(reset), .req(req4), .gnt_bus(d1_bus),
        .gnt(d1_gnt), .empty(d1_empty), .gnt_idx(d1_idx), .gnt_idx_q(d1_idx_q), .empty_q(d1_empty_q));
    psel_gen #(.WIDTH(4), .REQS(2)) d2 (.clock(clock), .reset(reset), .req(req4), .gnt_bus(d2_bus),
        .gnt(d2_gnt), .empty(d2_empty), .gnt_idx(d2_idx), .gnt_idx_q(d2_idx_q), .empty_q(d2_empty_q));
    psel_gen #(.WIDTH(4), .REQS(4)) d4 (.clock(clock), .reset(reset), .req(req4), .gnt_bus(d4_bus),
        .gnt(d4_gnt), .empty(d4_empty), .gnt_idx(d4_idx), .gnt_idx_q(d4_idx_q), .empty_q(d4_empty_q));
    psel_gen #(.WIDTH(8), .REQS(3)) d8 (.clock(clock), .reset(reset), .req(req8), .gnt_bus(d8_bus),
        .gnt(d8_gnt), .empty(d8_empty), .gnt_idx(d8_idx), .gnt_idx_q(d8_idx_q), .empty_q(d8_empty_q));
    psel_gen #(.WIDTH(1), .REQS(1)) w1 (.clock(clock), .reset(reset), .req(req1), .gnt_bus(w1_bus),
        .gnt(w1_gnt), .empty(w1_empty), .gnt_idx(w1_idx), .gnt_idx_q(w1_idx_q), .empty_q(w1_empty_q));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];   // {empty, idx} expected on the next edge

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- directed vectors (WIDTH=4) ----------------
    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  g1;    // d1 gnt (= its only row)
        logic [7:0]  b2;    // d2 gnt_bus
        logic [3:0]  g2;
        logic [15:0] b4;    // d4 gnt_bus
        logic [3:0]  g4;
        logic [2:0]  idx;
        logic        emp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{4'b0110, 4'b0010, 8'h42, 4'b0110, 16'h0042, 4'b0110, 3'd1, 1'b0};
        vecs[1] = '{4'b1011, 4'b0001, 8'h21, 4'b0011, 16'h0821, 4'b1011, 3'd0, 1'b0};
        vecs[2] = '{4'b1111, 4'b0001, 8'h21, 4'b0011, 16'h8421, 4'b1111, 3'd0, 1'b0};
        vecs[3] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 16'h0000, 4'b0000, 3'd4, 1'b1};
        vecs[4] = '{4'b1000, 4'b1000, 8'h08, 4'b1000, 16'h0008, 4'b1000, 3'd3, 1'b0};
        vecs[5] = '{4'b0100, 4'b0100, 8'h04, 4'b0100, 16'h0004, 4'b0100, 3'd2, 1'b0};
        vecs[6] = '{4'b1100, 4'b0100, 8'h84, 4'b1100, 16'h0084, 4'b1100, 3'd2, 1'b0};
    end

    task automatic drive_vec(input vec_t v);
        logic [4:0] e;
        @(negedge clock);
        req4 = v.req;
        #1;
        check("d1_gnt_bus", 32'(d1_bus), 32'(v.g1));
        check("d1_gnt",     32'(d1_gnt), 32'(v.g1));
        check("d2_gnt_bus", 32'(d2_bus), 32'(v.b2));
        check("d2_gnt",     32'(d2_gnt), 32'(v.g2));
        check("d4_gnt_bus", 32'(d4_bus), 32'(v.b4));
        check("d4_gnt",     32'(d4_gnt), 32'(v.g4));
        check("d1_idx",     32'(d1_idx), 32'(v.idx));
        check("d2_idx",     32'(d2_idx), 32'(v.idx));
        check("d4_idx",     32'(d4_idx), 32'(v.idx));
        check("d1_empty",   32'(d1_empty), 32'(v.emp));
        exp_q.push_back({v.emp, 1'b0, v.idx});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check("d1_idx_q",   32'(d1_idx_q),   32'(e[2:0]));
        check("d1_empty_q", 32'(d1_empty_q), 32'(e[4]));
    endtask

    // ---------------- reference model for WIDTH=8, REQS=3 ----------------
    // Walks req from bit 0 upward and gives the n-th set bit to row n.
    task automatic model8(input logic [7:0] r, output logic [23:0] bus,
                          output logic [3:0] first, output int cnt);
        int n;
        bus   = '0;
        first = 4'd8;
        n     = 0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                if (n == 0) first = 4'(i);
                if (n < 3) bus[n*8 + i] = 1'b1;
                n++;
            end
        end
        cnt = (n < 3) ? n : 3;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [23:0] mbus;
        logic [3:0]  mfirst;
        int          mcnt;
        logic [4:0]  e;

        req4 = 4'b0000;
        req8 = 8'h00;
        req1 = 1'b1;

        // Reset state of the registered pair.
        repeat (2) @(posedge clock);
        #1;
        check("rst_d1_idx_q",   32'(d1_idx_q),   32'd0);
        check("rst_d1_empty_q", 32'(d1_empty_q), 32'd1);
        check("rst_d8_idx_q",   32'(d8_idx_q),   32'd0);
        check("rst_d8_empty_q", 32'(d8_empty_q), 32'd1);
        check("rst_w1_empty_q", 32'(w1_empty_q), 32'd1);

        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) drive_vec(vecs[i]);

        // Reset overrides capture. After it is released, capture resumes.
        @(negedge clock);
        req4  = 4'b1000;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_idx_q",   32'(d1_idx_q),   32'd0);
        check("mid_rst_empty_q", 32'(d1_empty_q), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_idx_q",   32'(d1_idx_q),   32'd3);
        check("post_rst_empty_q", 32'(d1_empty_q), 32'd0);

        // WIDTH=1 boundary.
        @(negedge clock);
        req1 = 1'b0;
        #1;
        check("w1_zero_gnt",   32'(w1_gnt),   32'd0);
        check("w1_zero_empty", 32'(w1_empty), 32'd1);
        check("w1_zero_idx",   32'(w1_idx),   32'd1);
        @(negedge clock);
        req1 = 1'b1;
        #1;
        check("w1_one_bus",   32'(w1_bus),   32'd1);
        check("w1_one_empty", 32'(w1_empty), 32'd0);
        check("w1_one_idx",   32'(w1_idx),   32'd0);
        @(posedge clock);
        #1;
        check("w1_one_idx_q", 32'(w1_idx_q), 32'd0);

        // Random requests on the 8-wide, 3-grant instance.
        for (int t = 0; t < 1000; t++) begin
            @(negedge clock);
            req8 = (t % 50 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            #1;
            model8(req8, mbus, mfirst, mcnt);
            check("d8_gnt_bus", 32'(d8_bus), 32'(mbus));
            check("d8_disjoint", 32'((d8_bus[7:0] & d8_bus[15:8]) | (d8_bus[7:0] & d8_bus[23:16])
                                     | (d8_bus[15:8] & d8_bus[23:16])), 32'd0);
            check("d8_popcount", 32'($countones(d8_gnt)), 32'(mcnt));
            check("d8_idx",      32'(d8_idx), 32'(mfirst));
            check("d8_empty",    32'(d8_empty), 32'(req8 == 8'h00));
            exp_q.push_back({req8 == 8'h00, mfirst});
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            check("d8_idx_q",   32'(d8_idx_q),   32'(e[3:0]));
            check("d8_empty_q", 32'(d8_empty_q), 32'(e[4]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
